jtag_tap_master: RTL and testbench

- Synthesizable JTAG master that sequences the SCR1 debug JTAG bus (tck/tms/tdi/tdo/trst_n) from a simple command/response interface.
- Removes the dependency on a VPI-driven host: firmware, a bench sequencer or a UART bridge issues TAP reset, IR scan, DR scan and idle commands.
- Connects to the jtag_if master side in front of top.
- Tracks TAP state, generates divided TCK, shifts data LSB-first and returns captured TDO.

---
 rtl/jtag_master_pkg.sv | 29 ++
 rtl/jtag_tap_master_if.sv | 27 ++
 rtl/jtag_tck_gen.sv | 48 ++++
 rtl/jtag_tap_master.sv | 182 ++++++++++++++++++
 tb/tb_jtag_tap_master.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_master_pkg.sv
// Shared types and TMS sequence constants for the JTAG TAP master.
// All TMS constants are stored LSB-first: bit 0 is driven on the first TCK.
`timescale 1ns/1ps
package jtag_master_pkg;

  typedef enum logic [1:0] {
    TAP_RESET   = 2'd0,
    IR_SCAN     = 2'd1,
    DR_SCAN     = 2'd2,
    IDLE_CYCLES = 2'd3
  } jtag_op_e;

  typedef enum logic [1:0] {
    ST_AUTO_RST = 2'd0,
    ST_IDLE     = 2'd1,
    ST_RUN      = 2'd2,
    ST_RESP     = 2'd3
  } jtag_state_e;

  localparam logic [3:0] IR_PRE_TMS = 4'b0011;
  localparam int         IR_PRE_LEN = 4;
  localparam logic [2:0] DR_PRE_TMS = 3'b001;
  localparam int         DR_PRE_LEN = 3;
  localparam logic [1:0] SUF_TMS    = 2'b01;
  localparam int         SUF_LEN    = 2;
  localparam logic [5:0] RST_TMS    = 6'b011111;
  localparam int         RST_LEN    = 6;

endpackage

// File: rtl/jtag_tap_master_if.sv
// Command/response handshake between a sequencer and the JTAG TAP master.
`timescale 1ns/1ps
interface jtag_tap_master_if #(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7
);
  import jtag_master_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  jtag_op_e           cmd_op;
  logic [LEN_W-1:0]   cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [MAX_LEN-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/jtag_tck_gen.sv
// TCK divider: low half then high half, each TCK_HALF_DIV clk long.
// Strobes flag the clk edge on which tck will rise or fall.
`timescale 1ns/1ps
module jtag_tck_gen #(
  parameter int TCK_HALF_DIV = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tck,
  output logic tck_rise,
  output logic tck_fall
);
  localparam int CW = (TCK_HALF_DIV > 1) ? $clog2(TCK_HALF_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_q, tck_d;
  logic          half_end;

  assign half_end = (cnt_q == CW'(TCK_HALF_DIV - 1));
  assign tck_rise = en & ~tck_q & half_end;
  assign tck_fall = en &  tck_q & half_end;
  assign tck      = tck_q;

  always_comb begin
    cnt_d = cnt_q;
    tck_d = tck_q;
    if (!en) begin
      cnt_d = '0;
      tck_d = 1'b0;
    end else if (half_end) begin
      cnt_d = '0;
      tck_d = ~tck_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end
endmodule

// File: rtl/jtag_tap_master.sv
// JTAG master: sequences TAP reset, IR/DR scans and idle TCKs from a
// command/response handshake, shifting LSB-first and returning captured TDO.
`timescale 1ns/1ps
module jtag_tap_master import jtag_master_pkg::*; #(
  parameter int TCK_HALF_DIV = 12,
  parameter int MAX_LEN      = 64,
  parameter int LEN_W        = 7
) (
  input  logic              clk,
  input  logic              rst,
  jtag_tap_master_if.slave  bus,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo,
  output logic              trst_n
);
  localparam int CNT_W = LEN_W + 1;
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  typedef logic [CNT_W-1:0] cnt_t;

  function automatic logic [LEN_W-1:0] norm_len(jtag_op_e op, logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] l;
    l = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    if ((op == IR_SCAN || op == DR_SCAN) && l == '0) l = LEN_W'(1);
    return l;
  endfunction

  function automatic cnt_t pre_len(jtag_op_e op);
    case (op)
      IR_SCAN: return cnt_t'(IR_PRE_LEN);
      DR_SCAN: return cnt_t'(DR_PRE_LEN);
      default: return '0;
    endcase
  endfunction

  function automatic cnt_t seq_total(jtag_op_e op, logic [LEN_W-1:0] len);
    case (op)
      TAP_RESET: return cnt_t'(RST_LEN);
      IR_SCAN:   return {1'b0, len} + cnt_t'(IR_PRE_LEN + SUF_LEN);
      DR_SCAN:   return {1'b0, len} + cnt_t'(DR_PRE_LEN + SUF_LEN);
      default:   return {1'b0, len};
    endcase
  endfunction

  function automatic logic is_shift(jtag_op_e op, logic [LEN_W-1:0] len, cnt_t t);
    return (op == IR_SCAN || op == DR_SCAN) &&
           (t >= pre_len(op)) && (t < pre_len(op) + {1'b0, len});
  endfunction

  function automatic logic tms_at(jtag_op_e op, logic [LEN_W-1:0] len, cnt_t t);
    cnt_t pre, sh_end, suf_idx;
    pre     = pre_len(op);
    sh_end  = pre + {1'b0, len};
    suf_idx = t - sh_end;
    case (op)
      TAP_RESET: return RST_TMS[t[2:0]];
      IR_SCAN, DR_SCAN: begin
        if (t < pre) return (op == IR_SCAN) ? IR_PRE_TMS[t[1:0]] : DR_PRE_TMS[t[1:0]];
        if (t < sh_end) return (t == sh_end - cnt_t'(1));
        return SUF_TMS[suf_idx[0]];
      end
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic tdi_at(jtag_op_e op, logic [LEN_W-1:0] len,
                                  logic [MAX_LEN-1:0] data, cnt_t t);
    if (!is_shift(op, len, t)) return 1'b0;
    return data[IDX_W'(t - pre_len(op))];
  endfunction

  jtag_state_e        state_q, state_d;
  jtag_op_e           op_q, op_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  cnt_t               idx_q, idx_d;
  logic               tms_q, tms_d, tdi_q, tdi_d, trst_n_q, trst_n_d;
  logic               cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
  logic               tck_en, tck_rise, tck_fall;

  assign tck_en = (state_q == ST_RUN) || (state_q == ST_AUTO_RST);

  jtag_tck_gen #(.TCK_HALF_DIV(TCK_HALF_DIV)) u_tck_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (tck_en),
    .tck      (tck),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall)
  );

  // Next bit's tms/tdi are set on the falling strobe; tdo is taken on the rising one.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    len_d      = len_q;
    data_d     = data_q;
    idx_d      = idx_q;
    tms_d      = tms_q;
    tdi_d      = tdi_q;
    rsp_data_d = rsp_data_q;
    trst_n_d   = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          op_d       = bus.cmd_op;
          len_d      = norm_len(bus.cmd_op, bus.cmd_len);
          data_d     = bus.cmd_data;
          idx_d      = '0;
          rsp_data_d = '0;
          if (seq_total(op_d, len_d) == '0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_RUN;
            tms_d   = tms_at(op_d, len_d, '0);
            tdi_d   = tdi_at(op_d, len_d, data_d, '0);
          end
        end
      end
      ST_AUTO_RST, ST_RUN: begin
        if (tck_rise && is_shift(op_q, len_q, idx_q))
          rsp_data_d[IDX_W'(idx_q - pre_len(op_q))] = tdo;
        if (tck_fall) begin
          if (idx_q == seq_total(op_q, len_q) - cnt_t'(1)) begin
            idx_d   = '0;
            tms_d   = 1'b0;
            tdi_d   = 1'b0;
            state_d = (state_q == ST_AUTO_RST) ? ST_IDLE : ST_RESP;
          end else begin
            idx_d = idx_q + cnt_t'(1);
            tms_d = tms_at(op_q, len_q, idx_d);
            tdi_d = tdi_at(op_q, len_q, data_q, idx_d);
          end
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_AUTO_RST;
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_AUTO_RST;
      op_q        <= TAP_RESET;
      idx_q       <= '0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      trst_n_q    <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      trst_n_q    <= trst_n_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_ff @(posedge clk) begin
    len_q  <= len_d;
    data_q <= data_d;
  end

  assign tms           = tms_q;
  assign tdi           = tdi_q;
  assign trst_n        = trst_n_q;
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_jtag_tap_master.sv
// Directed bench for jtag_tap_master driving a behavioural TAP with a
// 5-bit IR (capture 5'b00001) and a 32-bit IDCODE register.
`timescale 1ns/1ps
module tb_jtag_tap_master;
  import jtag_master_pkg::*;

  localparam int HALF    = 12;
  localparam int MAX_LEN = 64;
  localparam int LEN_W   = 7;
  localparam logic [31:0] IDCODE_VAL = 32'h1234_5677;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tck, tms, tdi, trst_n;
  logic tdo = 1'b0;

  always #5 clk = ~clk;

  jtag_tap_master_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus ();

  jtag_tap_master #(.TCK_HALF_DIV(HALF), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .tck    (tck),
    .tms    (tms),
    .tdi    (tdi),
    .tdo    (tdo),
    .trst_n (trst_n)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural TAP target
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_e;

  function automatic tap_e tap_next(tap_e s, logic m);
    case (s)
      TLR:     return m ? TLR    : RTI;
      RTI:     return m ? SEL_DR : RTI;
      SEL_DR:  return m ? SEL_IR : CAP_DR;
      CAP_DR:  return m ? EX1_DR : SH_DR;
      SH_DR:   return m ? EX1_DR : SH_DR;
      EX1_DR:  return m ? UPD_DR : PA_DR;
      PA_DR:   return m ? EX2_DR : PA_DR;
      EX2_DR:  return m ? UPD_DR : SH_DR;
      UPD_DR:  return m ? SEL_DR : RTI;
      SEL_IR:  return m ? TLR    : CAP_IR;
      CAP_IR:  return m ? EX1_IR : SH_IR;
      SH_IR:   return m ? EX1_IR : SH_IR;
      EX1_IR:  return m ? UPD_IR : PA_IR;
      PA_IR:   return m ? EX2_IR : PA_IR;
      EX2_IR:  return m ? UPD_IR : SH_IR;
      default: return m ? SEL_DR : RTI;
    endcase
  endfunction

  tap_e        tap_st = TLR;
  logic [4:0]  ir_q   = 5'h01;
  logic [4:0]  ir_sr  = 5'h00;
  logic [31:0] dr_sr  = 32'h0;

  always @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tap_st <= TLR;
      ir_q   <= 5'h01;
    end else begin
      case (tap_st)
        TLR:    ir_q  <= 5'h01;
        CAP_IR: ir_sr <= 5'b00001;
        SH_IR:  ir_sr <= {tdi, ir_sr[4:1]};
        UPD_IR: ir_q  <= ir_sr;
        CAP_DR: dr_sr <= (ir_q == 5'h01) ? IDCODE_VAL : 32'h0;
        SH_DR:  if (ir_q == 5'h01) dr_sr <= {tdi, dr_sr[31:1]};
                else               dr_sr[0] <= tdi;
        default: ;
      endcase
      tap_st <= tap_next(tap_st, tms);
    end
  end

  always @(negedge tck)
    tdo <= (tap_st == SH_DR) ? dr_sr[0] : (tap_st == SH_IR) ? ir_sr[0] : 1'b0;

  // Pin history at each TCK rise, and a count of clocks with rsp_valid high
  int   tck_total = 0;
  int   rsp_clks  = 0;
  logic tms_hist [0:1023];
  logic tdi_hist [0:1023];

  always @(posedge tck) begin
    tms_hist[tck_total] <= tms;
    tdi_hist[tck_total] <= tdi;
    tck_total           <= tck_total + 1;
  end

  always @(posedge clk)
    if (bus.rsp_valid === 1'b1) rsp_clks <= rsp_clks + 1;

  task automatic get_log(input int start, input int n,
                         output logic [127:0] tv, output logic [127:0] dv);
    tv = '0;
    dv = '0;
    for (int i = 0; i < n && i < 128; i++) begin
      tv[i] = tms_hist[start + i];
      dv[i] = tdi_hist[start + i];
    end
  endtask

  // Releases rst (caller is #1 after a clk edge) and checks the auto TAP reset
  task automatic power_up(input string tag);
    int start, rs0, n;
    logic [127:0] tv, dv;
    start = tck_total;
    rs0   = rsp_clks;
    rst   = 1'b0;
    n     = 0;
    while (n < 400) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) chk($sformatf("%s_trst_n", tag), trst_n, 1'b1);
      if (bus.cmd_ready === 1'b1) break;
    end
    chk($sformatf("%s_ready_clks", tag), n, 144);
    chk($sformatf("%s_tck_count", tag), tck_total - start, 6);
    get_log(start, 6, tv, dv);
    chk($sformatf("%s_tms_seq", tag), tv, 128'h1F);
    chk($sformatf("%s_tdi_seq", tag), dv, 128'h0);
    chk($sformatf("%s_no_rsp", tag), rsp_clks - rs0, 0);
    chk($sformatf("%s_tap_rti", tag), tap_st, RTI);
  endtask

  task automatic issue(input jtag_op_e op, input logic [LEN_W-1:0] len,
                       input logic [63:0] data, output int start);
    int n;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("cmd_ready_wait", bus.cmd_ready, 1'b1);
    start         = tck_total;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_len   = len;
    bus.cmd_data  = data;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input jtag_op_e op, input logic [LEN_W-1:0] len,
                         input logic [63:0] data, input int hold,
                         output logic [63:0] rsp, output int ntck,
                         output logic [127:0] tv, output logic [127:0] dv);
    int start, n;
    bit bp_bad;
    issue(op, len, data, start);
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("%s_rsp_wait", tag), bus.rsp_valid, 1'b1);
    rsp  = bus.rsp_data;
    ntck = tck_total - start;
    get_log(start, ntck, tv, dv);
    bp_bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== rsp ||
          bus.cmd_ready !== 1'b0 || tck !== 1'b0) bp_bad = 1'b1;
    end
    if (hold > 0) chk($sformatf("%s_backpressure", tag), bp_bad, 1'b0);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk($sformatf("%s_rsp_drop", tag), bus.rsp_valid, 1'b0);
    chk($sformatf("%s_ready_back", tag), bus.cmd_ready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]  rsp;
    logic [127:0] tv, dv;
    int           ntck, start;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = TAP_RESET;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tck", tck, 1'b0);
    chk("rst_tms", tms, 1'b1);
    chk("rst_tdi", tdi, 1'b0);
    chk("rst_trst_n", trst_n, 1'b0);
    chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_data", bus.rsp_data, 64'h0);

    power_up("pwr");

    run_cmd("ir5", IR_SCAN, 7'd5, 64'h01, 0, rsp, ntck, tv, dv);
    chk("ir5_tck", ntck, 11);
    chk("ir5_tms", tv, 128'h303);
    chk("ir5_tdi", dv, 128'h10);
    chk("ir5_rsp", rsp, 64'h1);
    chk("ir5_ir_reg", ir_q, 5'h01);

    run_cmd("dr32", DR_SCAN, 7'd32, 64'h0, 50, rsp, ntck, tv, dv);
    chk("dr32_tck", ntck, 37);
    chk("dr32_tms", tv, 128'h0000_000C_0000_0001);
    chk("dr32_tdi", dv, 128'h0);
    chk("dr32_rsp", rsp, 64'h0000_0000_1234_5677);

    run_cmd("dr0", DR_SCAN, 7'd0, 64'hFFFF_FFFF_FFFF_FFFE, 0, rsp, ntck, tv, dv);
    chk("dr0_tck", ntck, 6);
    chk("dr0_tms", tv, 128'h19);
    chk("dr0_rsp", rsp, 64'h1);

    run_cmd("dr100", DR_SCAN, 7'd100, 64'hA5A5_0000_CAFE_BEEF, 0, rsp, ntck, tv, dv);
    chk("dr100_tck", ntck, 69);
    chk("dr100_tms", tv, 128'hC_0000_0000_0000_0001);
    chk("dr100_tdi", dv, 128'h5_2D28_0006_57F5_F778);
    chk("dr100_rsp", rsp, 64'hCAFE_BEEF_1234_5677);

    run_cmd("idle7", IDLE_CYCLES, 7'd7, 64'hFFFF, 0, rsp, ntck, tv, dv);
    chk("idle7_tck", ntck, 7);
    chk("idle7_tms", tv, 128'h0);
    chk("idle7_tdi", dv, 128'h0);
    chk("idle7_rsp", rsp, 64'h0);

    run_cmd("idle0", IDLE_CYCLES, 7'd0, 64'h0, 0, rsp, ntck, tv, dv);
    chk("idle0_tck", ntck, 0);
    chk("idle0_rsp", rsp, 64'h0);

    run_cmd("treset", TAP_RESET, 7'd0, 64'h0, 0, rsp, ntck, tv, dv);
    chk("treset_tck", ntck, 6);
    chk("treset_tms", tv, 128'h1F);
    chk("treset_rsp", rsp, 64'h0);

    // Reset during shift bit 10 (TCK index 13) of a 32-bit DR scan
    issue(DR_SCAN, 7'd32, 64'hFFFF_FFFF, start);
    ntck = 0;
    while (tck_total - start < 14 && ntck < 2000) begin
      @(posedge clk); #1;
      ntck++;
    end
    chk("mid_reach_bit10", tck_total - start, 14);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_tck", tck, 1'b0);
    chk("mid_tms", tms, 1'b1);
    chk("mid_trst_n", trst_n, 1'b0);
    chk("mid_rsp_valid", bus.rsp_valid, 1'b0);
    chk("mid_cmd_ready", bus.cmd_ready, 1'b0);
    power_up("rerun");

    run_cmd("post", DR_SCAN, 7'd32, 64'h0, 0, rsp, ntck, tv, dv);
    chk("post_tck", ntck, 37);
    chk("post_rsp", rsp, 64'h0000_0000_1234_5677);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
